// File: rtl/hazard_scoreboard_pkg.sv
// Shared ISA constants for the hazard scoreboard: register-file addressing
// and the encoding of the multi-cycle-unit (MDU) sequencer states.
package hazard_scoreboard_pkg;

    localparam int         REG_ADDR_W = 5;
    localparam logic [4:0] REG_X0     = 5'd0;

    localparam int         MDU_STATE_W = 2;
    localparam logic [1:0] MDU_IDLE    = 2'd0;
    localparam logic [1:0] MDU_BUSY    = 2'd1;
    localparam logic [1:0] MDU_DONE    = 2'd2;

endpackage

// File: rtl/hazard_scoreboard_fwd_select.sv
// Single-port forwarding priority matcher: picks the youngest forwarding
// stage that writes the requested source register, or 0 for the register file.
module fwd_select
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int SEL_W   = 2
) (
    input  logic [4:0]           rs,
    input  logic [NUM_FWD*5-1:0] rd_fwd,
    input  logic [NUM_FWD-1:0]   regwrite_fwd,
    output logic [SEL_W-1:0]     sel
);

    // Scan oldest to youngest so the lowest matching index wins.
    always_comb begin
        sel = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (regwrite_fwd[i] && (rd_fwd[i*5 +: 5] != REG_X0) &&
                (rd_fwd[i*5 +: 5] == rs)) begin
                sel = SEL_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding, load-use and scoreboard stalls,
// and the sequencer tracking one outstanding multi-cycle (MDU) operation.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int  NUM_RD  = 2,
    parameter int  NUM_FWD = 2,
    parameter int  MDU_LAT = 4,
    localparam int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_RD*5-1:0]     rs_id,
    input  logic [NUM_RD*5-1:0]     rs_ex,
    input  logic [NUM_FWD*5-1:0]    rd_fwd,
    input  logic [NUM_FWD-1:0]      regwrite_fwd,
    input  logic [4:0]              ex_rd,
    input  logic                    ex_regwrite,
    input  logic                    ex_is_load,
    input  logic                    issue_valid,
    input  logic                    issue_mdu,
    input  logic [4:0]              issue_rd,
    input  logic                    flush,
    output logic [NUM_RD*SEL_W-1:0] fwd_sel,
    output logic                    stall,
    output logic                    mdu_wb_valid,
    output logic [4:0]              mdu_wb_rd,
    output logic                    mdu_busy
);

    logic [MDU_STATE_W-1:0] state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [4:0]             rd_q, rd_d;
    logic [31:0]            pending_q, pending_d;

    logic load_use_haz, sb_haz, struct_haz, mdu_accept;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_fwd
            fwd_select #(
                .NUM_FWD (NUM_FWD),
                .SEL_W   (SEL_W)
            ) u_fwd_select (
                .rs           (rs_ex[gi*5 +: 5]),
                .rd_fwd       (rd_fwd),
                .regwrite_fwd (regwrite_fwd),
                .sel          (fwd_sel[gi*SEL_W +: SEL_W])
            );
        end
    endgenerate

    assign mdu_busy     = (state_q != MDU_IDLE);
    assign mdu_wb_valid = (state_q == MDU_DONE);
    assign mdu_wb_rd    = rd_q;

    always_comb begin
        load_use_haz = 1'b0;
        sb_haz       = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (ex_is_load && ex_regwrite && (ex_rd != REG_X0) &&
                (ex_rd == rs_id[p*5 +: 5])) begin
                load_use_haz = 1'b1;
            end
            if (pending_q[rs_id[p*5 +: 5]]) begin
                sb_haz = 1'b1;
            end
        end
        // WAW: do not let a younger write overtake the outstanding MDU result.
        if ((issue_rd != REG_X0) && pending_q[issue_rd]) begin
            sb_haz = 1'b1;
        end
        struct_haz = issue_valid && issue_mdu && mdu_busy;
        stall      = issue_valid && !flush && (load_use_haz || sb_haz || struct_haz);
        mdu_accept = issue_valid && !flush && !stall && issue_mdu;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        pending_d = pending_q;
        case (state_q)
            MDU_IDLE: begin
                if (mdu_accept) begin
                    state_d = MDU_BUSY;
                    cnt_d   = 4'(MDU_LAT - 1);
                    rd_d    = issue_rd;
                end
            end
            MDU_BUSY: begin
                // Counter hits zero as DONE is entered, so writeback lands MDU_LAT cycles after issue.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = MDU_DONE;
                end
            end
            MDU_DONE: begin
                state_d          = MDU_IDLE;
                pending_d[rd_q]  = 1'b0;
            end
            default: begin
                state_d = MDU_IDLE;
            end
        endcase
        if (mdu_accept && (issue_rd != REG_X0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MDU_IDLE;
            cnt_q     <= 4'd0;
            rd_q      <= 5'd0;
            pending_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard with default parameters.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rs_id, rs_ex, rd_fwd;
    logic [1:0]  regwrite_fwd;
    logic [4:0]  ex_rd;
    logic        ex_regwrite, ex_is_load;
    logic        issue_valid, issue_mdu;
    logic [4:0]  issue_rd;
    logic        flush;
    logic [3:0]  fwd_sel;
    logic        stall, mdu_wb_valid, mdu_busy;
    logic [4:0]  mdu_wb_rd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs_id        (rs_id),
        .rs_ex        (rs_ex),
        .rd_fwd       (rd_fwd),
        .regwrite_fwd (regwrite_fwd),
        .ex_rd        (ex_rd),
        .ex_regwrite  (ex_regwrite),
        .ex_is_load   (ex_is_load),
        .issue_valid  (issue_valid),
        .issue_mdu    (issue_mdu),
        .issue_rd     (issue_rd),
        .flush        (flush),
        .fwd_sel      (fwd_sel),
        .stall        (stall),
        .mdu_wb_valid (mdu_wb_valid),
        .mdu_wb_rd    (mdu_wb_rd),
        .mdu_busy     (mdu_busy)
    );

    task automatic idle_inputs();
        rs_id        = '0;
        rs_ex        = '0;
        rd_fwd       = '0;
        regwrite_fwd = '0;
        ex_rd        = '0;
        ex_regwrite  = 1'b0;
        ex_is_load   = 1'b0;
        issue_valid  = 1'b0;
        issue_mdu    = 1'b0;
        issue_rd     = '0;
        flush        = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        issue_valid = 1'b1;
        rs_id       = {5'd4, 5'd9};
        #1;
        n_checks++;
        if (mdu_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", mdu_busy);
        end
        n_checks++;
        if (mdu_wb_valid !== 1'b0 || mdu_wb_rd !== 5'd0) begin
            n_fail++; $display("FAIL reset_wb: got valid=%b rd=%0d want 0/0", mdu_wb_valid, mdu_wb_rd);
        end
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b want 0", stall);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_forwarding();
        logic [3:0] exp_sel [4];
        logic [9:0] t_rs_ex [4];
        logic [9:0] t_rd    [4];
        logic [1:0] t_we    [4];
        t_rs_ex = '{ {5'd0, 5'd5}, {5'd0, 5'd5}, {5'd0, 5'd5}, {5'd6, 5'd5} };
        t_rd    = '{ {5'd5, 5'd5}, {5'd5, 5'd5}, {5'd0, 5'd0}, {5'd6, 5'd5} };
        t_we    = '{ 2'b11,        2'b10,        2'b11,        2'b11 };
        exp_sel = '{ 4'b0001,      4'b0010,      4'b0000,      4'b1001 };
        for (int k = 0; k < 4; k++) begin
            rs_ex        = t_rs_ex[k];
            rd_fwd       = t_rd[k];
            regwrite_fwd = t_we[k];
            #1;
            n_checks++;
            if (fwd_sel !== exp_sel[k]) begin
                n_fail++; $display("FAIL fwd_sel_%0d: got %b want %b", k, fwd_sel, exp_sel[k]);
            end
            $display("fwd vec %0d: fwd_sel=%b", k, fwd_sel);
            @(negedge clk);
        end
        // Forwarding is independent of a concurrent load-use stall.
        rs_ex = {5'd0, 5'd5}; rd_fwd = {5'd5, 5'd5}; regwrite_fwd = 2'b10;
        ex_is_load = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd7;
        rs_id = {5'd7, 5'd0}; issue_valid = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b1 || fwd_sel !== 4'b0010) begin
            n_fail++; $display("FAIL fwd_under_stall: got stall=%b sel=%b want 1/0010", stall, fwd_sel);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_load_use();
        logic       t_load [4];
        logic [4:0] t_exrd [4];
        logic [9:0] t_rsid [4];
        logic       t_iv   [4];
        logic       exp_st [4];
        t_load = '{ 1'b1,          1'b1,          1'b0,          1'b1 };
        t_exrd = '{ 5'd7,          5'd0,          5'd7,          5'd7 };
        t_rsid = '{ {5'd7, 5'd3},  {5'd0, 5'd3},  {5'd7, 5'd3},  {5'd7, 5'd3} };
        t_iv   = '{ 1'b1,          1'b1,          1'b1,          1'b0 };
        exp_st = '{ 1'b1,          1'b0,          1'b0,          1'b0 };
        for (int k = 0; k < 4; k++) begin
            ex_is_load  = t_load[k];
            ex_regwrite = 1'b1;
            ex_rd       = t_exrd[k];
            rs_id       = t_rsid[k];
            issue_valid = t_iv[k];
            #1;
            n_checks++;
            if (stall !== exp_st[k]) begin
                n_fail++; $display("FAIL load_use_%0d: got stall=%b want %b", k, stall, exp_st[k]);
            end
            $display("load-use vec %0d: stall=%b", k, stall);
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_mdu_latency();
        issue_valid = 1'b1; issue_mdu = 1'b1; issue_rd = 5'd9; rs_id = {5'd1, 5'd2};
        #1;
        n_checks++;
        if (stall !== 1'b0 || mdu_wb_valid !== 1'b0 || mdu_busy !== 1'b0) begin
            n_fail++; $display("FAIL mdu_issue: got stall=%b wb=%b busy=%b want 0/0/0", stall, mdu_wb_valid, mdu_busy);
        end
        @(negedge clk);
        issue_mdu = 1'b0; issue_rd = 5'd3; rs_id = {5'd0, 5'd9};
        for (int k = 1; k <= 5; k++) begin
            #1;
            n_checks++;
            if (mdu_wb_valid !== (k == 4) || stall !== (k <= 4) || mdu_busy !== (k <= 4)) begin
                n_fail++; $display("FAIL mdu_lat_T+%0d: got wb=%b stall=%b busy=%b want %b/%b/%b",
                                   k, mdu_wb_valid, stall, mdu_busy, k == 4, k <= 4, k <= 4);
            end
            if (k == 4) begin
                n_checks++;
                if (mdu_wb_rd !== 5'd9) begin
                    n_fail++; $display("FAIL mdu_wb_rd: got %0d want 9", mdu_wb_rd);
                end
            end
            $display("mdu T+%0d: wb=%b rd=%0d stall=%b busy=%b", k, mdu_wb_valid, mdu_wb_rd, stall, mdu_busy);
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        issue_valid = 1'b1; issue_mdu = 1'b1; issue_rd = 5'd10;
        @(negedge clk);
        issue_rd = 5'd11;
        for (int k = 1; k <= 5; k++) begin
            #1;
            n_checks++;
            if (stall !== (k <= 4)) begin
                n_fail++; $display("FAIL struct_T+%0d: got stall=%b want %b", k, stall, k <= 4);
            end
            $display("second mdu T+%0d: stall=%b wb=%b", k, stall, mdu_wb_valid);
            @(negedge clk);
        end
        // Second op accepted at T+5; a non-MDU write to x11 is held by WAW until its writeback.
        issue_mdu = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            #1;
            n_checks++;
            if (stall !== (k <= 4) || mdu_wb_valid !== (k == 4)) begin
                n_fail++; $display("FAIL waw_T+%0d: got stall=%b wb=%b want %b/%b", k, stall, mdu_wb_valid, k <= 4, k == 4);
            end
            if (k == 4) begin
                n_checks++;
                if (mdu_wb_rd !== 5'd11) begin
                    n_fail++; $display("FAIL second_wb_rd: got %0d want 11", mdu_wb_rd);
                end
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        ex_is_load = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd7;
        rs_id = {5'd7, 5'd0}; issue_valid = 1'b1; flush = 1'b1;
        issue_mdu = 1'b1; issue_rd = 5'd12;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_stall: got %b want 0", stall);
        end
        @(negedge clk);
        idle_inputs();
        issue_valid = 1'b1; rs_id = {5'd0, 5'd12};
        #1;
        n_checks++;
        if (mdu_busy !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_no_update: got busy=%b stall=%b want 0/0", mdu_busy, stall);
        end
        @(negedge clk);
        // A flush after acceptance must not cancel the in-flight op.
        issue_mdu = 1'b1; issue_rd = 5'd13; rs_id = '0;
        @(negedge clk);
        issue_mdu = 1'b0; issue_rd = 5'd0; flush = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            n_checks++;
            if (mdu_wb_valid !== (k == 4)) begin
                n_fail++; $display("FAIL flush_inflight_T+%0d: got wb=%b want %b", k, mdu_wb_valid, k == 4);
            end
            @(negedge clk);
        end
        n_checks++;
        if (mdu_wb_rd !== 5'd13) begin
            n_fail++; $display("FAIL flush_inflight_rd: got %0d want 13", mdu_wb_rd);
        end
        $display("flush tests: last wb_rd=%0d", mdu_wb_rd);
        idle_inputs();
    endtask

    task automatic test_reset_mid_op();
        issue_valid = 1'b1; issue_mdu = 1'b1; issue_rd = 5'd14;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        issue_valid = 1'b1; rs_id = {5'd0, 5'd14};
        #1;
        n_checks++;
        if (mdu_busy !== 1'b1 || stall !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset: got busy=%b stall=%b want 1/1", mdu_busy, stall);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mdu_busy !== 1'b0 || stall !== 1'b0 || mdu_wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got busy=%b stall=%b wb=%b want 0/0/0", mdu_busy, stall, mdu_wb_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_checks++;
            if (mdu_wb_valid !== 1'b0 || mdu_busy !== 1'b0) begin
                n_fail++; $display("FAIL post_reset_%0d: got wb=%b busy=%b want 0/0", k, mdu_wb_valid, mdu_busy);
            end
            @(negedge clk);
        end
        $display("reset mid-op: busy=%b wb=%b", mdu_busy, mdu_wb_valid);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_mdu_latency();
        test_back_to_back();
        test_flush();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
